// File: rtl/seq_shifter.sv
// ============================================================================
// Module   : seq_shifter
// Purpose  : Multi-cycle, mode-selectable shifter (LSR/LSL/ASR/ROR), one bit
//            position per clock, with busy/done handshake and carry-out.
// Options  : SEQ_SHIFTER_ROTATE_EN - when defined, mode 11 rotates right;
//            otherwise mode 11 behaves exactly as LSR.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_shifter #(
  parameter int WIDTH = 4,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] in_i,
  input  logic [AMT_W-1:0] amt_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] out_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             carry_o
);

  localparam logic [1:0]       C_MODE_LSR = 2'b00;
  localparam logic [1:0]       C_MODE_LSL = 2'b01;
  localparam logic [1:0]       C_MODE_ASR = 2'b10;
  localparam logic [1:0]       C_MODE_ROR = 2'b11;
  localparam logic [AMT_W-1:0] C_WIDTH    = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] C_ONE      = AMT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] out_q;
  logic [AMT_W-1:0] cnt_q;
  logic [1:0]       mode_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;

  logic [1:0]       mode_d;
  logic [AMT_W-1:0] eff_d;

  // Decode the requested mode and the effective step count at start time.
  always_comb begin
    mode_d = mode_i;
    eff_d  = (amt_i > C_WIDTH) ? C_WIDTH : amt_i;
`ifdef SEQ_SHIFTER_ROTATE_EN
    // Rotation by WIDTH is the identity, so only the residue matters.
    if (mode_i == C_MODE_ROR) begin
      eff_d = amt_i % C_WIDTH;
    end
`else
    // Without the rotate datapath, mode 11 is folded onto LSR up front.
    if (mode_i == C_MODE_ROR) begin
      mode_d = C_MODE_LSR;
    end
`endif
  end

  // Control FSM and datapath: latch on start, one shift per edge, pulse done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= C_MODE_LSR;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            out_q   <= in_i;
            mode_q  <= mode_d;
            cnt_q   <= eff_d;
            carry_q <= 1'b0;
            if (eff_d == '0) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_SHIFT;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end

        ST_SHIFT: begin
          case (mode_q)
            C_MODE_LSL: begin
              carry_q <= out_q[WIDTH-1];
              out_q   <= {out_q[WIDTH-2:0], 1'b0};
            end
            C_MODE_ASR: begin
              carry_q <= out_q[0];
              out_q   <= {out_q[WIDTH-1], out_q[WIDTH-1:1]};
            end
`ifdef SEQ_SHIFTER_ROTATE_EN
            C_MODE_ROR: begin
              carry_q <= out_q[0];
              out_q   <= {out_q[0], out_q[WIDTH-1:1]};
            end
`endif
            default: begin
              carry_q <= out_q[0];
              out_q   <= {1'b0, out_q[WIDTH-1:1]};
            end
          endcase
          cnt_q <= cnt_q - C_ONE;
          if (cnt_q == C_ONE) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_o   = out_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign carry_o = carry_q;

endmodule

`default_nettype wire
